if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
Next-generation instruction fetch stage. It replaces the single-PC fetch with a decoupled front end: it issues sequential fetch requests to instruction memory through a valid/ready handshake and buffers returned instructions, with their PCs, in a prefetch FIFO. Decode drains the FIFO through a valid/ready handshake. Redirects (jump/branch/JALR) flush the buffer and discard stale in-flight responses.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h00000000, first fetch address after reset
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
MAX_OUTSTANDING, 2, maximum in-flight memory requests; 1..DEPTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect  in  1  jump taken; flush and refetch from redirect_addr
redirect_addr  in  XLEN  jump target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address, word aligned
imem_rsp_valid  in  1  in-order response valid; always accepted, no backpressure
imem_rsp_data  in  32  instruction word
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts instruction; deasserted = stall
id_instr  out  32  instruction
id_pc  out  XLEN  PC of id_instr

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset: fetch_pc <= RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0. While reset is high, imem_req_valid = 0 and id_valid = 0.
- State:
  - fetch_pc (XLEN)
  - FIFO of {pc, instr}, DEPTH entries
  - in-flight PC queue, MAX_OUTSTANDING entries
  - outstanding counter
  - drop_cnt counter
- Credit rule: imem_req_valid = !reset && !redirect && (outstanding < MAX_OUTSTANDING) && (fifo_count + outstanding - drop_cnt < DEPTH). The FIFO can never overflow.
- imem_req_addr = fetch_pc.
- Request accepted (valid && ready):
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
  - fetch_pc is pushed into the in-flight queue.
  - outstanding increments.
- Response:
  - outstanding decrements and the in-flight queue pops.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise {popped pc, imem_rsp_data} is pushed into the FIFO.
  - A response while outstanding == 0 is a protocol violation and is ignored.
- Same-cycle accept and response: outstanding is unchanged; both queue operations occur.
- Decode side:
  - id_valid = FIFO not empty; id_instr/id_pc = FIFO head.
  - Pop on id_valid && id_ready.
  - Simultaneous push and pop is legal at any fill level.
- Redirect (takes priority over everything):
  - Next cycle: FIFO empty; fetch_pc = {redirect_addr[XLEN-1:2], 2'b00}.
  - drop_cnt <= outstanding after this cycle's accept/response updates.
  - The in-flight queue keeps its PCs so dropped responses still pop in order.
  - No request is issued in the redirect cycle.
  - A decode handshake in the same cycle completes normally; decode owns that instruction.
- Back-to-back redirects: the last one wins. drop_cnt accumulates all in-flight requests.
- Latency: an instruction is visible on id_* the cycle after its response arrives (see optional feature). Steady state with zero-wait memory and id_ready = 1: one instruction per cycle when MAX_OUTSTANDING >= 2.
- Reset mid-operation: everything is cleared as at reset. Responses to pre-reset requests are ignored; the memory is reset concurrently.

Optional Feature:
IF_RSP_BYPASS_EN
- Defined: when the FIFO is empty, drop_cnt == 0, and imem_rsp_valid is high, the response drives id_* combinationally in the same cycle with id_valid = 1. If id_ready is also high, the response is not written into the FIFO.
- Undefined: every response goes through the FIFO, adding one cycle of latency. There is no combinational path from imem_rsp_* to id_*.

Test Plan:
- Reset then free-running memory (ready = 1, 1-cycle response), id_ready = 1: id_pc sequence 0x0, 0x4, 0x8, ... one per cycle after fill. imem_req_valid = 0 during reset.
- id_ready = 0 for 10 cycles: the FIFO fills to DEPTH = 4; imem_req_valid drops once fifo_count + outstanding = 4; no instruction is lost or duplicated; release resumes at the correct PC.
- Redirect to 0x100 with 2 requests outstanding: both responses are dropped; the next id_pc is 0x100, then 0x104; no stale instruction appears.
- Redirect to 0x203: the fetch address is 0x200.
- Redirect coinciding with a decode handshake and a memory response: the handshake completes, the FIFO is empty next cycle, and the response is dropped.
- fetch_pc = 0xFFFFFFFC, accepted request: the next request address wraps to 0x0.
- With IF_RSP_BYPASS_EN, empty FIFO, response 0x00000013 at PC 0x0: id_valid = 1 the same cycle. Without the macro, id_valid = 1 one cycle later.

Source files
------------

// File: rtl/if_prefetch.sv
// if_prefetch: decoupled instruction fetch front end.
// Sequential fetch requests go to instruction memory over a valid/ready
// handshake. Returned words are buffered with their PCs in a prefetch FIFO,
// and decode drains that FIFO over a valid/ready handshake. A redirect flushes
// the FIFO, restarts fetch at the word-aligned target, and marks every
// in-flight request so its stale response is discarded when it returns.
//
// Optional build macro IF_RSP_BYPASS_EN: when the FIFO is empty and nothing is
// pending drop, a response is presented on id_* in the same cycle it arrives.
// If decode takes it in that cycle, it is not written to the FIFO.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   redirect, redirect_addr    flush and refetch from redirect_addr
//   imem_req_valid/ready/addr  fetch request channel (addr word aligned)
//   imem_rsp_valid/data        in-order response channel, never backpressured
//   id_valid/ready/instr/pc    decode channel (FIFO head)
module if_prefetch #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = CW + OW;

  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_count;

  logic [XLEN-1:0] infl_pc [MAX_OUTSTANDING];
  logic [QW-1:0]   q_wr, q_rd;

  logic [OW-1:0]   outstanding, outstanding_next;
  logic [OW-1:0]   drop_cnt;

  logic            req_fire, rsp_fire, rsp_drop, rsp_keep;
  logic            fifo_empty, fifo_push, fifo_pop;
  logic [SW-1:0]   slots_used;
  logic [1:0]      unused_addr_bits;

  assign unused_addr_bits = redirect_addr[1:0];

  assign fifo_empty = (fifo_count == '0);

  // Slots already committed: buffered entries plus requests whose responses
  // will actually land in the FIFO (dropped ones never take a slot).
  assign slots_used = SW'(fifo_count) + SW'(outstanding) - SW'(drop_cnt);

  assign imem_req_valid = !reset && !redirect
                       && (outstanding < OW'(MAX_OUTSTANDING))
                       && (slots_used < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp_fire = !reset && imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_fire && (drop_cnt != '0);
  assign rsp_keep = rsp_fire && (drop_cnt == '0);

`ifdef IF_RSP_BYPASS_EN
  logic bypass;
  assign bypass    = rsp_keep && fifo_empty;
  assign id_valid  = !reset && (!fifo_empty || bypass);
  assign id_instr  = bypass ? imem_rsp_data : fifo_instr[rd_ptr];
  assign id_pc     = bypass ? infl_pc[q_rd] : fifo_pc[rd_ptr];
  assign fifo_push = rsp_keep && !redirect && !(bypass && id_ready);
`else
  assign id_valid  = !reset && !fifo_empty;
  assign id_instr  = fifo_instr[rd_ptr];
  assign id_pc     = fifo_pc[rd_ptr];
  assign fifo_push = rsp_keep && !redirect;
`endif

  assign fifo_pop = id_valid && id_ready && !fifo_empty;

  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !rsp_fire)
      outstanding_next = outstanding + OW'(1);
    else if (!req_fire && rsp_fire)
      outstanding_next = outstanding - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;

      if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        q_wr     <= (q_wr == QW'(MAX_OUTSTANDING - 1)) ? '0 : q_wr + QW'(1);
      end
      // The in-flight queue pops even for dropped responses so PCs stay paired.
      if (rsp_fire)
        q_rd <= (q_rd == QW'(MAX_OUTSTANDING - 1)) ? '0 : q_rd + QW'(1);

      if (redirect) begin
        fetch_pc   <= {redirect_addr[XLEN-1:2], 2'b00};
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        // Everything still in flight after this cycle is stale; this also
        // covers responses already marked by an earlier redirect.
        drop_cnt   <= outstanding_next;
      end else begin
        if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
        if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
        if (fifo_push && !fifo_pop)
          fifo_count <= fifo_count + CW'(1);
        else if (!fifo_push && fifo_pop)
          fifo_count <= fifo_count - CW'(1);
        if (rsp_drop) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by pointers/counters.
  always_ff @(posedge clk) begin
    if (req_fire)
      infl_pc[q_wr] <= fetch_pc;
    if (fifo_push) begin
      fifo_pc[wr_ptr]    <= infl_pc[q_rd];
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed, scoreboard-checked bench for if_prefetch.
// A memory model answers accepted requests one cycle later (or holds them
// while mem_hold is set). Expected decode PCs are queued by the stimulus and
// compared, with the matching instruction word, whenever decode takes one.
// Decode only accepts while the bench expects something, so each phase
// consumes exactly the instructions it queued.
// Build with +define+IF_RSP_BYPASS_EN to check the bypass latency instead.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  if_prefetch #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .DEPTH(4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          phase_consumes = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic        mem_hold = 1'b0;
  logic        hold_id = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] pend[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h0000_0013 ^ (a << 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: set decode ready, settle, sample/check, clock, then update the
  // memory model for the new cycle.
  task automatic step();
    logic        req_fire_s;
    logic [31:0] addr_s;
    logic [31:0] pc_e;
    id_ready = !hold_id && (exp_q.size() != 0);
    #1;
    req_fire_s = imem_req_valid && imem_req_ready;
    addr_s     = imem_req_addr;
    if (id_valid && id_ready) begin
      pc_e = exp_q.pop_front();
      check("id_pc", id_pc, pc_e);
      check("id_instr", id_instr, instr_of(pc_e));
      if (phase_consumes == 0) first_cyc = cyc;
      last_cyc = cyc;
      phase_consumes++;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (reset) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      if (req_fire_s) pend.push_back(addr_s);
      if (!mem_hold && pend.size() != 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_seq(input logic [31:0] base, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;

    // Reset: no request and no decode output while reset is high.
    repeat (3) step();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check("rst_req_valid_after", 32'(imem_req_valid), 32'd1);

    // Free-running stream: 16 instructions, one per cycle once filled.
    push_seq(32'h0, 16);
    phase_consumes = 0;
    drain("drain_stream", 60);
    check("throughput", 32'(last_cyc - first_cyc), 32'd15);

    // Decode stall: FIFO fills, requests stop, nothing lost on release.
    hold_id = 1'b1;
    repeat (10) step();
    #1;
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_id_valid", 32'(id_valid), 32'd1);
    hold_id = 1'b0;
    push_seq(32'h40, 8);
    drain("drain_stall", 40);

    // Misaligned redirect with memory held: fetch address is aligned, then
    // two requests go out and the outstanding limit stops further issue.
    repeat (6) step();
    mem_hold      = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0203;
    step();
    redirect = 1'b0;
    #1;
    check("redir_align_addr", imem_req_addr, 32'h0000_0200);
    check("redir_flush_a", 32'(id_valid), 32'd0);
    repeat (4) step();
    #1;
    check("max_outstanding", 32'(imem_req_valid), 32'd0);

    // Redirect with two requests outstanding: both responses must be dropped.
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0100;
    step();
    redirect = 1'b0;
    mem_hold = 1'b0;
    push_seq(32'h100, 8);

    // Redirect while decode takes the last expected entry and a response
    // arrives: handshake completes, FIFO empty next cycle, response dropped.
    n = 0;
    while (!(exp_q.size() == 1 && id_valid) && n < 60) begin
      step();
      n++;
    end
    check("redir_hs_setup", 32'(exp_q.size()), 32'd1);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0400;
    step();
    redirect = 1'b0;
    #1;
    check("redir_hs_consumed", 32'(exp_q.size()), 32'd0);
    check("redir_hs_flush", 32'(id_valid), 32'd0);
    check("redir_hs_addr", imem_req_addr, 32'h0000_0400);
    push_seq(32'h400, 4);
    drain("drain_redir", 30);

    // Address wrap at the top of the address space.
    repeat (6) step();
    redirect      = 1'b1;
    redirect_addr = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    #1;
    check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    #1;
    check("wrap_addr_zero", imem_req_addr, 32'h0000_0000);
    exp_q.push_back(32'hFFFF_FFFC);
    push_seq(32'h0, 3);
    drain("drain_wrap", 30);

    // Mid-operation reset, then response latency for PC 0 (word 0x13).
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    reset   = 1'b0;
    hold_id = 1'b1;
    exp_q.push_back(32'h0);
    step();
    #1;
    check("lat_rsp_present", 32'(imem_rsp_valid), 32'd1);
`ifdef IF_RSP_BYPASS_EN
    check("lat_same_cycle", 32'(id_valid), 32'd1);
    check("lat_bypass_instr", id_instr, 32'h0000_0013);
`else
    check("lat_same_cycle", 32'(id_valid), 32'd0);
`endif
    step();
    #1;
    check("lat_next_valid", 32'(id_valid), 32'd1);
    check("lat_next_instr", id_instr, 32'h0000_0013);
    check("lat_next_pc", id_pc, 32'h0000_0000);
    hold_id = 1'b0;
    drain("drain_lat", 10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
